// File: rtl/trace_capture_core_if.sv
// Readout stream bundle for trace_capture_core.
// master: the capture core (drives valid/data/last); slave: the readout consumer.
interface trace_capture_core_if #(
    parameter int TRACE_W = 6
) ();
    logic               rd_valid;
    logic               rd_ready;
    logic [TRACE_W-1:0] rd_data;
    logic               rd_last;

    modport master (
        output rd_valid,
        output rd_data,
        output rd_last,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_data,
        input  rd_last,
        output rd_ready
    );
endinterface

// File: rtl/trace_capture_core.sv
// trace_capture_core: logic-analyzer capture engine.
// Samples trace_din into a circular buffer, fires on a masked compare of
// trigger_din, keeps pre_trig samples before the trigger, fills the rest of
// the buffer after it, then streams the capture out oldest-first.
// Optional macro TRACE_CAPTURE_TRIG_EDGE_EN adds the trig_edge input, which
// makes the trigger fire only on a rising edge of the match condition.
module trace_capture_core #(
    parameter int TRACE_W = 6,
    parameter int TRIG_W  = 6,
    parameter int DEPTH   = 64,
    parameter int ADDR_W  = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [TRIG_W-1:0]   trigger_din,
    input  logic [TRACE_W-1:0]  trace_din,
    input  logic                trigger_en,
    input  logic [TRIG_W-1:0]   trig_value,
    input  logic [TRIG_W-1:0]   trig_mask,
    input  logic [ADDR_W-1:0]   pre_trig,
`ifdef TRACE_CAPTURE_TRIG_EDGE_EN
    input  logic                trig_edge,
`endif
    input  logic                arm,
    input  logic                stop,
    output logic                armed,
    output logic                triggered,
    output logic                done,
    output logic [ADDR_W-1:0]   trig_pos,
    trace_capture_core_if.master rd_bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_POST = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_END  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_LAST = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);

    logic [TRACE_W-1:0] mem [DEPTH];

    logic [2:0]         state;
    logic [ADDR_W-1:0]  pre_q;
    logic [ADDR_W-1:0]  pre_cnt;
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  post_left;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [ADDR_W:0]    rd_cnt;
    logic               trig_hit;
    logic               out_valid;
    logic               out_last;
    logic [TRACE_W-1:0] out_data;

    logic               match;
    logic               fire;
    logic               capturing;
    logic               xfer;

`ifdef TRACE_CAPTURE_TRIG_EDGE_EN
    logic               match_q;

    // Previous-cycle match; held at 0 outside WAIT so a condition already true
    // on entry to WAIT counts as a rising edge on the first WAIT cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_q <= 1'b0;
        end else begin
            match_q <= (state == S_WAIT) ? match : 1'b0;
        end
    end
`endif

    // Trigger qualification, capture window and handshake decode.
    always_comb begin
        match     = trigger_en && (((trigger_din ^ trig_value) & trig_mask) == '0);
`ifdef TRACE_CAPTURE_TRIG_EDGE_EN
        fire      = match && (!trig_edge || !match_q);
`else
        fire      = match;
`endif
        capturing = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
        xfer      = out_valid && rd_bus.rd_ready;
    end

    // Sample buffer: one write per cycle while a capture is in progress.
    always_ff @(posedge clk) begin
        if (capturing) begin
            mem[wr_ptr] <= trace_din;
        end
    end

    // Capture sequencing and readout stream.
    // The trigger address is never stored: the readout start pointer
    // (trigger address minus pre_q) is loaded directly on the trigger cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            pre_q     <= '0;
            pre_cnt   <= '0;
            wr_ptr    <= '0;
            post_left <= '0;
            rd_ptr    <= '0;
            rd_cnt    <= '0;
            trig_hit  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (stop) begin
            state     <= S_IDLE;
            trig_hit  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arm) begin
                        pre_q   <= pre_trig;
                        wr_ptr  <= '0;
                        pre_cnt <= '0;
                        state   <= (pre_trig == '0) ? S_WAIT : S_PRE;
                    end
                end

                S_PRE: begin
                    wr_ptr  <= wr_ptr + ONE;
                    pre_cnt <= pre_cnt + ONE;
                    if (pre_cnt + ONE == pre_q) begin
                        state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    wr_ptr <= wr_ptr + ONE;
                    if (fire) begin
                        trig_hit  <= 1'b1;
                        post_left <= LAST_IDX - pre_q;
                        rd_ptr    <= wr_ptr - pre_q;
                        rd_cnt    <= '0;
                        state     <= (pre_q == LAST_IDX) ? S_DONE : S_POST;
                    end
                end

                S_POST: begin
                    wr_ptr    <= wr_ptr + ONE;
                    post_left <= post_left - ONE;
                    if (post_left == ONE) begin
                        state <= S_DONE;
                    end
                end

                S_DONE: begin
                    if (xfer && out_last) begin
                        state     <= S_IDLE;
                        trig_hit  <= 1'b0;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end else if (!out_valid || rd_bus.rd_ready) begin
                        if (rd_cnt != CNT_END) begin
                            out_valid <= 1'b1;
                            out_data  <= mem[rd_ptr];
                            out_last  <= (rd_cnt == CNT_LAST);
                            rd_ptr    <= rd_ptr + ONE;
                            rd_cnt    <= rd_cnt + CNT_ONE;
                        end else begin
                            out_valid <= 1'b0;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Status and stream outputs.
    always_comb begin
        armed           = capturing;
        done            = (state == S_DONE);
        triggered       = trig_hit;
        trig_pos        = pre_q;
        rd_bus.rd_valid = out_valid;
        rd_bus.rd_data  = out_data;
        rd_bus.rd_last  = out_last;
    end

endmodule

// File: tb/tb_trace_capture_core.sv
// Testbench for trace_capture_core (DEPTH=16).
// Reference model: records every sample/match value driven since arm, finds
// the trigger index from the capture rules and slices the expected readout.
module tb_trace_capture_core;

    localparam int TRACE_W = 6;
    localparam int TRIG_W  = 6;
    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic [TRIG_W-1:0]  trigger_din;
    logic [TRACE_W-1:0] trace_din;
    logic               trigger_en;
    logic [TRIG_W-1:0]  trig_value;
    logic [TRIG_W-1:0]  trig_mask;
    logic [ADDR_W-1:0]  pre_trig;
`ifdef TRACE_CAPTURE_TRIG_EDGE_EN
    logic               trig_edge;
`endif
    logic               arm;
    logic               stop;
    logic               armed;
    logic               triggered;
    logic               done;
    logic [ADDR_W-1:0]  trig_pos;

    int checks = 0;
    int errors = 0;

    trace_capture_core_if #(.TRACE_W(TRACE_W)) rd_bus ();

    trace_capture_core #(
        .TRACE_W (TRACE_W),
        .TRIG_W  (TRIG_W),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .trigger_din (trigger_din),
        .trace_din   (trace_din),
        .trigger_en  (trigger_en),
        .trig_value  (trig_value),
        .trig_mask   (trig_mask),
        .pre_trig    (pre_trig),
`ifdef TRACE_CAPTURE_TRIG_EDGE_EN
        .trig_edge   (trig_edge),
`endif
        .arm         (arm),
        .stop        (stop),
        .armed       (armed),
        .triggered   (triggered),
        .done        (done),
        .trig_pos    (trig_pos),
        .rd_bus      (rd_bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Per-cycle stimulus; k=-1 is the arm cycle, k>=0 are capture cycles.
    function automatic void gen(input int mode, input int k, input logic [5:0] val,
                                output logic [5:0] tr, output logic [5:0] tg, output logic en);
        en = 1'b1;
        tr = 6'($urandom);
        tg = 6'($urandom);
        case (mode)
            0: begin tr = 6'(k + 1); tg = 6'(k + 1); end
            2: begin tg = val; en = (k >= 40); end
            3: tg = val;
            4: tg = (k < 8) ? ~val : val;
            default: ;
        endcase
    endfunction

    task automatic capture(input int pre, input logic [5:0] val, input logic [5:0] mask,
                           input int mode, input bit edge_mode, output logic [5:0] exp_q[$]);
        logic [5:0] samp[$];
        bit         mt[$];
        int         t = -1;
        bit         ended = 0;
        logic [5:0] tr, tg;
        logic       en;
        exp_q = {};
        @(negedge clk);
        trig_value = val;
        trig_mask  = mask;
        pre_trig   = 4'(pre);
`ifdef TRACE_CAPTURE_TRIG_EDGE_EN
        trig_edge  = edge_mode;
`endif
        gen(mode, -1, val, tr, tg, en);
        trace_din = tr; trigger_din = tg; trigger_en = en;
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        chk("armed_after_arm", armed, 1);
        for (int k = 0; k < 200; k++) begin
            gen(mode, k, val, tr, tg, en);
            trace_din = tr; trigger_din = tg; trigger_en = en;
            arm = (k == 3);
            samp.push_back(tr);
            mt.push_back(en && (((tg ^ val) & mask) == 6'd0));
            if (t < 0 && k >= pre && mt[k] && (!edge_mode || k == pre || !mt[k-1]))
                t = k;
            @(negedge clk);
            chk("triggered", triggered, t >= 0);
            if (t >= 0 && k == t + DEPTH - 1 - pre) begin
                chk("done_at_end", done, 1);
                chk("armed_at_end", armed, 0);
                chk("trig_pos", trig_pos, pre);
                ended = 1;
                break;
            end
            chk("armed_capture", armed, 1);
            chk("done_capture", done, 0);
        end
        arm = 1'b0;
        chk("capture_ended", ended, 1);
        if (ended)
            for (int i = 0; i < DEPTH; i++) exp_q.push_back(samp[t - pre + i]);
    endtask

    task automatic readout(input logic [5:0] exp_q[$], input int stall_at, input int stop_at);
        int         idx = 0;
        int         stalls = 0;
        bit         seen = 0;
        bit         held = 0;
        logic [5:0] held_data = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!seen) begin
                if (rd_bus.rd_valid === 1'b1) seen = 1;
                else if (cyc >= 2) begin
                    chk("first_valid_latency", rd_bus.rd_valid, 1);
                    break;
                end
            end
            if (held && rd_bus.rd_valid) chk("stall_data_stable", rd_bus.rd_data, held_data);
            if (seen && stop_at == idx) begin
                stop = 1'b1;
                rd_bus.rd_ready = 1'b1;
                @(negedge clk);
                stop = 1'b0;
                chk("stop_done", done, 0);
                chk("stop_valid", rd_bus.rd_valid, 0);
                chk("stop_triggered", triggered, 0);
                chk("stop_armed", armed, 0);
                return;
            end
            if (stall_at == idx && stalls < 3 && rd_bus.rd_valid) begin
                rd_bus.rd_ready = 1'b0;
                stalls++;
            end else begin
                rd_bus.rd_ready = ($urandom_range(0, 3) != 0);
            end
            held      = rd_bus.rd_valid && !rd_bus.rd_ready;
            held_data = rd_bus.rd_data;
            if (rd_bus.rd_valid && rd_bus.rd_ready) begin
                chk("rd_data", rd_bus.rd_data, exp_q[idx]);
                chk("rd_last", rd_bus.rd_last, idx == DEPTH - 1);
                idx++;
            end
            @(negedge clk);
            if (idx == DEPTH) begin
                rd_bus.rd_ready = 1'b0;
                chk("end_done", done, 0);
                chk("end_triggered", triggered, 0);
                chk("end_valid", rd_bus.rd_valid, 0);
                chk("end_armed", armed, 0);
                return;
            end
        end
        chk("readout_count", idx, DEPTH);
    endtask

    initial begin
        logic [5:0] exp_q[$];
        logic [5:0] v;

        reset = 1'b1;
        trigger_din = '0; trace_din = '0; trigger_en = 1'b0;
        trig_value = '0; trig_mask = '0; pre_trig = '0;
`ifdef TRACE_CAPTURE_TRIG_EDGE_EN
        trig_edge = 1'b0;
`endif
        arm = 1'b0; stop = 1'b0;
        rd_bus.rd_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_armed", armed, 0);
        chk("rst_triggered", triggered, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", rd_bus.rd_valid, 0);
        chk("rst_last", rd_bus.rd_last, 0);
        chk("rst_data", rd_bus.rd_data, 0);
        chk("rst_trig_pos", trig_pos, 0);
        reset = 1'b0;

        // Counter pattern, trigger on value 0x0A with 4 pre-trigger samples.
        capture(4, 6'h0A, 6'h3F, 0, 1'b0, exp_q);
        readout(exp_q, -1, -1);

        // Always-match, no pre-trigger samples.
        capture(0, 6'h00, 6'h00, 1, 1'b0, exp_q);
        readout(exp_q, -1, -1);

        // Maximum pre-trigger: no post samples.
        v = 6'($urandom);
        capture(15, v, 6'h03, 1, 1'b0, exp_q);
        readout(exp_q, -1, -1);

        // Trigger disabled for 40 cycles while the value matches.
        capture(4, 6'h15, 6'h3F, 2, 1'b0, exp_q);
        readout(exp_q, -1, -1);

        // Backpressure: 3-cycle stall at sample 5.
        v = 6'($urandom);
        capture(7, v, 6'h07, 1, 1'b0, exp_q);
        readout(exp_q, 5, -1);

        // Stop mid-readout, then a fresh capture must work.
        capture(2, 6'h00, 6'h00, 1, 1'b0, exp_q);
        readout(exp_q, -1, 9);
        v = 6'($urandom);
        capture(9, v, 6'h07, 1, 1'b0, exp_q);
        readout(exp_q, -1, -1);

        // Stop during capture, and stop together with arm in IDLE.
        @(negedge clk);
        pre_trig = 4'd3; trig_mask = 6'h3F; trig_value = 6'h3F;
        trigger_din = 6'h00; trigger_en = 1'b1;
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        repeat (5) @(negedge clk);
        chk("wait_armed", armed, 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_cap_armed", armed, 0);
        chk("stop_cap_triggered", triggered, 0);
        arm = 1'b1; stop = 1'b1;
        @(negedge clk);
        arm = 1'b0; stop = 1'b0;
        chk("stop_over_arm", armed, 0);

        // Asynchronous reset mid-capture after the trigger.
        pre_trig = 4'd0; trig_mask = 6'h00;
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_reset_triggered", triggered, 1);
        reset = 1'b1;
        #1;
        chk("arst_triggered", triggered, 0);
        chk("arst_armed", armed, 0);
        chk("arst_trig_pos", trig_pos, 0);
        chk("arst_valid", rd_bus.rd_valid, 0);
        @(negedge clk);
        reset = 1'b0;

`ifdef TRACE_CAPTURE_TRIG_EDGE_EN
        // Edge mode: condition true before arm fires on the first WAIT cycle.
        capture(2, 6'h0A, 6'h3F, 3, 1'b1, exp_q);
        readout(exp_q, -1, -1);
        // Edge mode: low-to-high transition mid-wait.
        capture(2, 6'h0A, 6'h3F, 4, 1'b1, exp_q);
        readout(exp_q, -1, -1);
        // Level mode with the port present.
        capture(2, 6'h0A, 6'h3F, 4, 1'b0, exp_q);
        readout(exp_q, -1, -1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
